// File: rtl/noise_gate_pkg.sv
// noise_gate_pkg: shared types and helpers for the noise gate.
//   gate_state_t : gate FSM states
//   unity()      : unity gain value for a given number of gain fraction bits
//   abs_sat()    : magnitude of a dw-bit signed sample, most-negative saturated
package noise_gate_pkg;

  typedef enum logic [2:0] {
    CLOSED,
    ATTACK,
    OPEN,
    HOLD,
    RELEASE
  } gate_state_t;

  function automatic int unsigned unity(input int unsigned gain_w);
    return 32'd1 << gain_w;
  endfunction

  // x is a dw-bit sample sign-extended to 32 bits; -2**(dw-1) has no positive
  // twin in dw bits, so it maps to 2**(dw-1)-1.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x,
                                          input int unsigned dw);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (dw - 1));
    if (x == most_neg)
      return (32'd1 << (dw - 1)) - 32'd1;
    else if (x < 0)
      return $unsigned(-x);
    else
      return $unsigned(x);
  endfunction

endpackage

// File: rtl/noise_gate_peak_env.sv
// noise_gate_peak_env: peak envelope follower (pipeline stage S2).
//   clk, rst_n : clock, synchronous active-low reset
//   v1         : stage-1 valid; the envelope advances only on valid samples
//   abs1       : stage-1 sample magnitude
//   env        : registered envelope
//   env_next   : combinational envelope for the sample currently in stage 1
module noise_gate_peak_env
  import noise_gate_pkg::*;
#(
  parameter int unsigned ENV_W       = 15,
  parameter int unsigned DECAY_SHIFT = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v1,
  input  logic [ENV_W-1:0] abs1,
  output logic [ENV_W-1:0] env,
  output logic [ENV_W-1:0] env_next
);

  logic [ENV_W-1:0] dec;
  logic [ENV_W-1:0] decayed;

  // Minimum decay of 1 keeps small envelopes from sticking above zero.
  always_comb begin
    dec = env >> DECAY_SHIFT;
    if (dec == '0 && env != '0)
      dec = ENV_W'(1);
    decayed  = env - dec;
    env_next = (abs1 > decayed) ? abs1 : decayed;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      env <= '0;
    else if (v1)
      env <= env_next;
  end

endmodule

// File: rtl/noise_gate.sv
// noise_gate: sample-strobed downward noise gate (3-stage pipeline).
//   clk, rst_n    : clock, synchronous active-low reset
//   sample_en     : one-cycle strobe per audio sample, qualifies data_i
//   data_i        : signed input sample
//   open_thresh   : envelope level that opens the gate
//   close_thresh  : envelope level below which closing starts (clamped to open_thresh)
//   hold_len      : samples held open after the envelope falls below close level
//   attack_step   : gain increment per sample while attacking
//   release_step  : gain decrement per sample while releasing
//   data_o        : gated sample, held between valid_o pulses
//   valid_o       : one-cycle pulse, 3 clks after the sample_en cycle
//   gate_open_o   : high when the gate is not CLOSED, aligned with data_o
//   env_o         : registered envelope aligned with data_o; present only when
//                   NOISE_GATE_ENV_OUT_EN is defined
module noise_gate
  import noise_gate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned GAIN_W      = 8,
  parameter int unsigned HOLD_W      = 16,
  parameter int unsigned DECAY_SHIFT = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_en,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic        [DATA_WIDTH-2:0] open_thresh,
  input  logic        [DATA_WIDTH-2:0] close_thresh,
  input  logic        [HOLD_W-1:0]     hold_len,
  input  logic        [GAIN_W-1:0]     attack_step,
  input  logic        [GAIN_W-1:0]     release_step,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         valid_o,
  output logic                         gate_open_o
`ifdef NOISE_GATE_ENV_OUT_EN
  ,
  output logic        [DATA_WIDTH-2:0] env_o
`endif
);

  localparam logic [GAIN_W:0] UNITY = (GAIN_W + 1)'(unity(GAIN_W));
  localparam int unsigned     PW    = DATA_WIDTH + GAIN_W + 2;

  // S1
  logic signed [DATA_WIDTH-1:0] x1;
  logic        [DATA_WIDTH-2:0] abs1;
  logic                         v1;
  logic        [31:0]           abs_full;
  logic                         unused_abs;

  assign abs_full   = abs_sat(32'(data_i), DATA_WIDTH);
  assign unused_abs = ^abs_full[31:DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x1   <= '0;
      abs1 <= '0;
      v1   <= 1'b0;
    end else begin
      v1 <= sample_en;
      if (sample_en) begin
        x1   <= data_i;
        abs1 <= abs_full[DATA_WIDTH-2:0];
      end
    end
  end

  // S2: envelope + gate FSM
  logic [DATA_WIDTH-2:0] env;
  logic [DATA_WIDTH-2:0] env_next;

  noise_gate_peak_env #(
    .ENV_W       (DATA_WIDTH - 1),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_peak_env (
    .clk      (clk),
    .rst_n    (rst_n),
    .v1       (v1),
    .abs1     (abs1),
    .env      (env),
    .env_next (env_next)
  );

  gate_state_t                  state, state_next;
  logic        [GAIN_W:0]       gain, gain_next;
  logic        [HOLD_W-1:0]     hold_cnt, hold_next;
  logic        [DATA_WIDTH-2:0] eff_close;
  logic                         ge_open, lt_close;
  logic        [GAIN_W:0]       gain_sum, gain_up, gain_dn;
  logic signed [DATA_WIDTH-1:0] x2;
  logic                         v2;

  // gain <= UNITY, so gain + step cannot overflow GAIN_W+1 bits.
  always_comb begin
    eff_close = (close_thresh < open_thresh) ? close_thresh : open_thresh;
    ge_open   = (env_next >= open_thresh);
    lt_close  = (env_next < eff_close);
    gain_sum  = gain + {1'b0, attack_step};
    gain_up   = (gain_sum > UNITY) ? UNITY : gain_sum;
    gain_dn   = ({1'b0, release_step} >= gain) ? '0 : gain - {1'b0, release_step};
  end

  // Gain follows the state being entered on the same sample.
  always_comb begin
    state_next = state;
    gain_next  = gain;
    hold_next  = hold_cnt;
    if (v1) begin
      unique case (state)
        CLOSED: begin
          if (ge_open) begin
            state_next = ATTACK;
            gain_next  = gain_up;
          end else begin
            gain_next = '0;
          end
        end
        ATTACK: begin
          if (lt_close) begin
            state_next = RELEASE;
            gain_next  = gain_dn;
          end else if (gain_up == UNITY) begin
            state_next = OPEN;
            gain_next  = UNITY;
          end else begin
            gain_next = gain_up;
          end
        end
        OPEN: begin
          gain_next = UNITY;
          if (lt_close) begin
            state_next = HOLD;
            hold_next  = hold_len;
          end
        end
        HOLD: begin
          gain_next = UNITY;
          if (ge_open) begin
            state_next = OPEN;
          end else if (hold_cnt == '0) begin
            state_next = RELEASE;
            gain_next  = gain_dn;
          end else begin
            hold_next = hold_cnt - HOLD_W'(1);
          end
        end
        RELEASE: begin
          if (ge_open) begin
            state_next = ATTACK;
            gain_next  = gain_up;
          end else if (gain_dn == '0) begin
            state_next = CLOSED;
            gain_next  = '0;
          end else begin
            gain_next = gain_dn;
          end
        end
        default: begin
          state_next = CLOSED;
          gain_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLOSED;
      gain     <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      gain     <= gain_next;
      hold_cnt <= hold_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x2 <= '0;
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1)
        x2 <= x1;
    end
  end

  // S3: arithmetic shift of the signed product floors toward -inf.
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;
  logic                 unused_scaled;

  assign prod          = $signed(PW'(x2)) * $signed(PW'({1'b0, gain}));
  assign scaled        = prod >>> GAIN_W;
  assign unused_scaled = ^scaled[PW-1:DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      gate_open_o <= 1'b0;
`ifdef NOISE_GATE_ENV_OUT_EN
      env_o       <= '0;
`endif
    end else begin
      valid_o <= v2;
      if (v2) begin
        data_o      <= scaled[DATA_WIDTH-1:0];
        gate_open_o <= (state != CLOSED);
`ifdef NOISE_GATE_ENV_OUT_EN
        env_o       <= env;
`endif
      end
    end
  end

`ifndef NOISE_GATE_ENV_OUT_EN
  logic unused_env;
  assign unused_env = ^env;
`endif

endmodule

// File: tb/tb_noise_gate.sv
// tb_noise_gate: directed self-checking bench for noise_gate.
module tb_noise_gate;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sample_en;
  logic signed [15:0] data_i;
  logic        [14:0] open_thresh;
  logic        [14:0] close_thresh;
  logic        [15:0] hold_len;
  logic        [7:0]  attack_step;
  logic        [7:0]  release_step;
  logic signed [15:0] data_o;
  logic               valid_o;
  logic               gate_open_o;
`ifdef NOISE_GATE_ENV_OUT_EN
  logic        [14:0] env_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  noise_gate #(
    .DATA_WIDTH  (16),
    .GAIN_W      (8),
    .HOLD_W      (16),
    .DECAY_SHIFT (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .data_i       (data_i),
    .open_thresh  (open_thresh),
    .close_thresh (close_thresh),
    .hold_len     (hold_len),
    .attack_step  (attack_step),
    .release_step (release_step),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .gate_open_o  (gate_open_o)
`ifdef NOISE_GATE_ENV_OUT_EN
    ,
    .env_o        (env_o)
`endif
  );

  always #5 clk = ~clk;

  // Envelope reference: decay by env>>6 (at least 1 when nonzero), peak-hold on |x|.
  function automatic int env_step(input int env, input int a);
    int dec;
    dec = env >>> 6;
    if (dec == 0 && env != 0) dec = 1;
    env = env - dec;
    return (a > env) ? a : env;
  endfunction

  task automatic set_cfg(input int op, input int cl, input int hl, input int as, input int rs);
    open_thresh  = 15'(op);
    close_thresh = 15'(cl);
    hold_len     = 16'(hl);
    attack_step  = 8'(as);
    release_step = 8'(rs);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    sample_en = 1'b0;
    data_i    = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Strobe one sample and wait (bounded) for its output pulse.
  task automatic do_sample(input logic signed [15:0] d, output logic signed [15:0] q,
                           output logic g, output int lat);
    @(negedge clk);
    sample_en = 1'b1;
    data_i    = d;
    @(negedge clk);
    sample_en = 1'b0;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (valid_o !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL sample_timeout: valid_o=%b after %0d clks, required 1", valid_o, lat);
    end
    q = data_o;
    g = gate_open_o;
  endtask

  task automatic test_reset();
    logic signed [15:0] q;
    logic g;
    int lat;
    set_cfg(1000, 500, 3, 64, 128);
    rst_n = 1'b0; sample_en = 1'b0; data_i = '0;
    repeat (5) @(negedge clk);
    n_checks++; if (data_o !== 16'sd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", data_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_checks++; if (gate_open_o !== 1'b0) begin n_fail++; $display("FAIL reset_gate: got %b want 0", gate_open_o); end
    rst_n = 1'b1;
    do_sample(16'sd2000, q, g, lat);
    do_sample(16'sd2000, q, g, lat);
    n_checks++; if (q !== 16'sd1000) begin n_fail++; $display("FAIL pre_reset_ramp: got %0d want 1000", q); end
    // Strobe a sample, then reset while it is in flight.
    @(negedge clk); sample_en = 1'b1; data_i = 16'sd2000;
    @(negedge clk); sample_en = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL inflight_valid[%0d]: got %b want 0", i, valid_o); end
    end
    n_checks++; if (data_o !== 16'sd0) begin n_fail++; $display("FAIL midreset_data: got %0d want 0", data_o); end
    n_checks++; if (gate_open_o !== 1'b0) begin n_fail++; $display("FAIL midreset_gate: got %b want 0", gate_open_o); end
    rst_n = 1'b1;
    do_sample(16'sd2000, q, g, lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL latency: got %0d want 3", lat); end
    n_checks++; if (q !== 16'sd500) begin n_fail++; $display("FAIL post_reset_gain: got %0d want 500", q); end
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL post_reset_gate: got %b want 1", g); end
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL valid_pulse_width: got %b want 0", valid_o); end
  endtask

  task automatic test_attack();
    logic signed [15:0] q;
    logic g;
    int lat;
    int exp_q[5] = '{500, 1000, 1500, 2000, 2000};
    apply_reset();
    set_cfg(1000, 500, 3, 64, 128);
    for (int i = 0; i < 5; i++) begin
      do_sample(16'sd2000, q, g, lat);
      n_checks++; if (q !== 16'(exp_q[i])) begin n_fail++; $display("FAIL attack_data[%0d]: got %0d want %0d", i, q, exp_q[i]); end
      n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL attack_gate[%0d]: got %b want 1", i, g); end
    end
  endtask

  // Continues from an OPEN gate with envelope 2000.
  task automatic test_hold_release();
    logic signed [15:0] q;
    logic g;
    logic exp_g;
    int lat;
    int env_m = 2000;
    int k = -1;
    bit done = 0;
    set_cfg(1000, 500, 3, 64, 128);
    for (int i = 0; i < 300 && !done; i++) begin
      env_m = env_step(env_m, 0);
      if (k < 0 && env_m < 500) k = i;
      exp_g = (k < 0) || (i <= k + 4);
      do_sample(16'sd0, q, g, lat);
      n_checks++; if (q !== 16'sd0) begin n_fail++; $display("FAIL hold_data[%0d]: got %0d want 0", i, q); end
      n_checks++; if (g !== exp_g) begin n_fail++; $display("FAIL hold_gate[%0d]: got %b want %b (k=%0d)", i, g, exp_g, k); end
      if (k >= 0 && i == k + 5) done = 1;
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL hold_never_closed: k=%0d", k); end
  endtask

  // Starts CLOSED with a small envelope.
  task automatic test_hysteresis();
    logic signed [15:0] q;
    logic g;
    int lat;
    set_cfg(1000, 500, 3, 64, 128);
    for (int i = 0; i < 4; i++) begin
      do_sample(16'sd700, q, g, lat);
      n_checks++; if (q !== 16'sd0) begin n_fail++; $display("FAIL hyst_closed_data[%0d]: got %0d want 0", i, q); end
      n_checks++; if (g !== 1'b0) begin n_fail++; $display("FAIL hyst_closed_gate[%0d]: got %b want 0", i, g); end
    end
    for (int i = 0; i < 4; i++) do_sample(16'sd2000, q, g, lat);
    n_checks++; if (q !== 16'sd2000) begin n_fail++; $display("FAIL hyst_reopen: got %0d want 2000", q); end
    for (int i = 0; i < 6; i++) begin
      do_sample(16'sd700, q, g, lat);
      n_checks++; if (q !== 16'sd700) begin n_fail++; $display("FAIL hyst_open_data[%0d]: got %0d want 700", i, q); end
      n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL hyst_open_gate[%0d]: got %b want 1", i, g); end
    end
  endtask

  task automatic test_boundary();
    logic signed [15:0] q;
    logic g;
    int lat;
    apply_reset();
    set_cfg(1000, 500, 3, 64, 128);
    do_sample(-16'sd32768, q, g, lat);
    n_checks++; if (q !== -16'sd8192) begin n_fail++; $display("FAIL min_sample_opens: got %0d want -8192", q); end
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL min_sample_gate: got %b want 1", g); end
    do_sample(-16'sd1001, q, g, lat);
    n_checks++; if (q !== -16'sd501) begin n_fail++; $display("FAIL floor_rounding: got %0d want -501", q); end
    do_sample(-16'sd32768, q, g, lat);
    n_checks++; if (q !== -16'sd24576) begin n_fail++; $display("FAIL min_gain192: got %0d want -24576", q); end
    do_sample(-16'sd32768, q, g, lat);
    n_checks++; if (q !== -16'sd32768) begin n_fail++; $display("FAIL min_unity: got %0d want -32768", q); end
    do_sample(16'sd32767, q, g, lat);
    n_checks++; if (q !== 16'sd32767) begin n_fail++; $display("FAIL max_unity: got %0d want 32767", q); end
  endtask

  task automatic test_close_above_open();
    logic signed [15:0] q;
    logic g;
    logic exp_g;
    int lat;
    int env_m = 1500;
    int k = -1;
    bit done = 0;
    apply_reset();
    set_cfg(1000, 2000, 0, 64, 128);
    do_sample(16'sd1500, q, g, lat);
    n_checks++; if (q !== 16'sd375) begin n_fail++; $display("FAIL cao_first: got %0d want 375", q); end
    for (int i = 0; i < 3; i++) do_sample(16'sd1500, q, g, lat);
    n_checks++; if (q !== 16'sd1500) begin n_fail++; $display("FAIL cao_open: got %0d want 1500", q); end
    for (int i = 0; i < 100 && !done; i++) begin
      env_m = env_step(env_m, 0);
      if (k < 0 && env_m < 1000) k = i;
      exp_g = (k < 0) || (i <= k + 1);
      do_sample(16'sd0, q, g, lat);
      n_checks++; if (g !== exp_g) begin n_fail++; $display("FAIL cao_gate[%0d]: got %b want %b (k=%0d)", i, g, exp_g, k); end
      if (k >= 0 && i == k + 2) done = 1;
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL cao_never_closed: k=%0d", k); end
  endtask

  task automatic test_retrigger();
    logic signed [15:0] q;
    logic g;
    int lat;
    apply_reset();
    set_cfg(1000, 500, 0, 64, 128);
    for (int i = 0; i < 4; i++) do_sample(16'sd2000, q, g, lat);
    n_checks++; if (q !== 16'sd2000) begin n_fail++; $display("FAIL retrig_open: got %0d want 2000", q); end
    set_cfg(4000, 4000, 0, 64, 128);
    do_sample(16'sd1000, q, g, lat);
    n_checks++; if (q !== 16'sd1000) begin n_fail++; $display("FAIL retrig_hold: got %0d want 1000", q); end
    do_sample(16'sd1000, q, g, lat);
    n_checks++; if (q !== 16'sd500) begin n_fail++; $display("FAIL retrig_release128: got %0d want 500", q); end
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL retrig_release_gate: got %b want 1", g); end
    set_cfg(1000, 500, 0, 64, 128);
    do_sample(16'sd3000, q, g, lat);
    n_checks++; if (q !== 16'sd2250) begin n_fail++; $display("FAIL retrig_gain192: got %0d want 2250", q); end
    do_sample(16'sd3000, q, g, lat);
    n_checks++; if (q !== 16'sd3000) begin n_fail++; $display("FAIL retrig_unity: got %0d want 3000", q); end
  endtask

  task automatic test_zero_attack();
    logic signed [15:0] q;
    logic g;
    int lat;
    apply_reset();
    set_cfg(1000, 500, 3, 0, 128);
    for (int i = 0; i < 3; i++) begin
      do_sample(16'sd2000, q, g, lat);
      n_checks++; if (q !== 16'sd0) begin n_fail++; $display("FAIL zero_attack_data[%0d]: got %0d want 0", i, q); end
      n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL zero_attack_gate[%0d]: got %b want 1", i, g); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; data_i = '0;
    set_cfg(1000, 500, 3, 64, 128);
    test_reset();
    test_attack();
    test_hold_release();
    test_hysteresis();
    test_boundary();
    test_close_above_open();
    test_retrigger();
    test_zero_attack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
